// File: rtl/xpb_table_gen_if.sv
// Bus for xpb_table_gen: start/load handshake, status flags, table read port.
// master drives start, base_in, mod_in, rd_addr; slave drives busy, done, table_valid, rd_data.
interface xpb_table_gen_if #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5
);
  logic                start;
  logic [WIDTH-1:0]    base_in;
  logic [WIDTH-1:0]    mod_in;
  logic                busy;
  logic                done;
  logic                table_valid;
  logic [SEL_BITS-1:0] rd_addr;
  logic [WIDTH-1:0]    rd_data;

  modport master (
    output start, base_in, mod_in, rd_addr,
    input  busy, done, table_valid, rd_data
  );

  modport slave (
    input  start, base_in, mod_in, rd_addr,
    output busy, done, table_valid, rd_data
  );
endinterface

// File: rtl/xpb_table_gen.sv
// Builds table[k] = k*B mod M (k = 0..2^SEL_BITS-1) with a limb-serial adder.
// Ports: clk, rst_n (async, active-low), bus (slave: start/B/M in, status + registered read out).
module xpb_table_gen #(
  parameter int WIDTH    = 1024,
  parameter int SEL_BITS = 5,
  parameter int LIMB_W   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  xpb_table_gen_if.slave bus
);

  localparam int NL   = WIDTH / LIMB_W;
  localparam int LI_W = (NL > 1) ? $clog2(NL) : 1;
  localparam int NE   = 1 << SEL_BITS;

  localparam logic [LI_W-1:0]     LI_LAST = LI_W'(NL - 1);
  localparam logic [SEL_BITS-1:0] K_LAST  = '1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    ADD,
    WRITE,
    DONE
  } state_t;

  state_t              state;
  logic [WIDTH-1:0]    b_r;
  logic [WIDTH-1:0]    m_r;
  logic [WIDTH-1:0]    acc;
  logic [WIDTH-1:0]    sum_r;
  logic [WIDTH-1:0]    diff_r;
  logic [WIDTH-1:0]    tbl [NE];
  logic [LI_W-1:0]     li;
  logic [SEL_BITS-1:0] k;
  logic                carry;
  logic                borrow;
  logic                busy_r;
  logic                done_r;
  logic                valid_r;
  logic [WIDTH-1:0]    rd_r;

  logic [LIMB_W-1:0]   acc_l;
  logic [LIMB_W-1:0]   b_l;
  logic [LIMB_W-1:0]   m_l;
  logic [LIMB_W:0]     s_l;
  logic [LIMB_W:0]     d_l;
  logic [WIDTH-1:0]    result;

  // One limb of acc+B and of (acc+B)-M per cycle; the top bit of
  // s_l/d_l is the carry/borrow out into the next limb.
  always_comb begin
    acc_l = acc[li*LIMB_W +: LIMB_W];
    b_l   = b_r[li*LIMB_W +: LIMB_W];
    m_l   = m_r[li*LIMB_W +: LIMB_W];
    s_l   = {1'b0, acc_l} + {1'b0, b_l}
          + {{LIMB_W{1'b0}}, carry};
    d_l   = {1'b0, s_l[LIMB_W-1:0]} - {1'b0, m_l}
          - {{LIMB_W{1'b0}}, borrow};
  end

  // acc+B >= M exactly when the sum overflowed WIDTH bits
  // or the subtraction of M did not borrow.
  assign result = (carry | ~borrow) ? diff_r : sum_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      b_r     <= '0;
      m_r     <= '0;
      acc     <= '0;
      sum_r   <= '0;
      diff_r  <= '0;
      li      <= '0;
      k       <= '0;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      rd_r    <= '0;
      for (int i = 0; i < NE; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      rd_r   <= tbl[bus.rd_addr];
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            b_r     <= bus.base_in;
            m_r     <= bus.mod_in;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= INIT;
          end
        end
        INIT: begin
          tbl[0] <= '0;
          acc    <= '0;
          k      <= SEL_BITS'(1);
          li     <= '0;
          carry  <= 1'b0;
          borrow <= 1'b0;
          state  <= ADD;
        end
        ADD: begin
          sum_r[li*LIMB_W +: LIMB_W]  <= s_l[LIMB_W-1:0];
          diff_r[li*LIMB_W +: LIMB_W] <= d_l[LIMB_W-1:0];
          carry  <= s_l[LIMB_W];
          borrow <= d_l[LIMB_W];
          if (li == LI_LAST) begin
            state <= WRITE;
          end else begin
            li <= li + 1'b1;
          end
        end
        WRITE: begin
          tbl[k] <= result;
          acc    <= result;
          carry  <= 1'b0;
          borrow <= 1'b0;
          li     <= '0;
          if (k == K_LAST) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            k     <= k + 1'b1;
            state <= ADD;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          valid_r <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.table_valid = valid_r;
  assign bus.rd_data     = rd_r;

endmodule

// File: doc/xpb_table_gen.md
Name: xpb_table_gen

Overview:
- Runtime generator for the reduction lookup table consumed by the modular squaring datapath.
- Replaces a hardwired per-segment constant table: computes entry[k] = k·B mod M for k = 0..2^SEL_BITS−1 from a loaded base B and modulus M.
- Uses limb-serial add/subtract and stores the results in an internal register table.
- Exposes a registered read port, addressed by a segment value, to the squaring pipeline.

Parameters:
- WIDTH, 1024, bit width of M, B and each table entry.
- SEL_BITS, 5, table address width; the table holds 2^SEL_BITS entries.
- LIMB_W, 64, limb width of the serial adder; WIDTH mod LIMB_W must be 0; NL = WIDTH/LIMB_W.

Ports:
- clk  in  1  sole clock; all flops are rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin generation; sampled in IDLE only.
- base_in  in  WIDTH  B; caller guarantees B < M.
- mod_in  in  WIDTH  M; caller guarantees M odd, M > 1.
- busy  out  1  high from the cycle after start is accepted until DONE, inclusive.
- done  out  1  one-cycle pulse when the table is complete.
- table_valid  out  1  high after done; cleared by reset or by a new accepted start.
- rd_addr  in  SEL_BITS  segment value to look up.
- rd_data  out  WIDTH  registered table[rd_addr].

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state = IDLE; busy, done, table_valid, rd_data = 0.
  - All table entries = 0; limb counter, entry counter, carry and borrow = 0.
- States: IDLE → INIT → ADD → WRITE → (ADD | DONE) → IDLE.
- IDLE:
  - start = 1 latches B and M into internal registers and clears table_valid → INIT.
  - base_in and mod_in are ignored at all other times.
- INIT (1 cycle):
  - table[0] = 0; acc = 0; k = 1; limb index = 0; carry = 0; borrow = 0 → ADD.
- ADD (NL cycles, limb i = 0..NL−1, LSB first):
  - s_i = acc_i + B_i + carry.
  - d_i = s_i − M_i − borrow.
  - Limb i of the SUM and DIFF registers is stored; carry and borrow are updated.
  - After limb NL−1 → WRITE.
- WRITE (1 cycle):
  - Result = DIFF if (final carry = 1) or (final borrow = 0); otherwise SUM.
  - Result is the exact value of (acc + B) mod M; one conditional subtract suffices because acc, B < M.
  - table[k] = result; acc = result; carry and borrow cleared.
  - If k = 2^SEL_BITS − 1 → DONE; else k++ → ADD.
- DONE (1 cycle): done = 1, busy = 1, table_valid ← 1 → IDLE.
- Latency:
  - With start accepted at cycle t, done is high at cycle t + 2 + (2^SEL_BITS − 1)·(NL+1).
  - Default: t+529. WIDTH=16, LIMB_W=8: t+95.
- Read port:
  - rd_data ← table[rd_addr] every cycle, 1-cycle latency.
  - Reads are legal at any time. While busy, partially written content is returned; consumers gate on table_valid.
  - Read and write of the same entry in the same cycle returns the old value.
- Restart semantics:
  - start while busy is ignored.
  - start in the same cycle that DONE returns to IDLE is not seen until the following cycle.
  - A new accepted start leaves old entries readable until each is overwritten.
- Reset mid-run: immediate return to IDLE, table zeroed, no done pulse.
- B = 0: every entry = 0; the full latency still elapses.

Test Plan:
- WIDTH=16, LIMB_W=8, SEL_BITS=5; M=0xFFF1, B=0x1234; start pulse at cycle t:
  - done only at t+95.
  - Reads give entry1=0x1234, entry2=0x2468, entry31=0x346A.
  - entry0 = 0; table_valid = 1 thereafter.
- Same config, B=0xFFF0 (M−1), which exercises the carry-out path:
  - entry1=0xFFF0, entry2=0xFFEF (0x1FFE0 overflows, DIFF selected), entry31=0xFFD2.
- Default config, random odd 1024-bit M and random B < M:
  - All 32 entries match the golden model k·B mod M.
  - done at t+529; busy high over t+1..t+529.
- Start re-pulsed at t+10 and t+200 during a run:
  - Ignored; single done at t+529; results unchanged.
- rst_n dropped at t+50 mid-run:
  - busy=0, done=0, table_valid=0 and rd_data=0 asynchronously.
  - After release, a fresh start completes normally.
- Back-to-back runs with different B:
  - table_valid falls the cycle after the second start.
  - Entry values switch only as rewritten; final table matches the second B.
